// File: rtl/threat_pkg.sv
// Shared definitions for the threat-light monitor: state codes, light patterns, counter widths.
package threat_pkg;

    typedef enum logic [1:0] {
        GREEN    = 2'd0,
        YELLOW   = 2'd1,
        RED      = 2'd2,
        LOCKDOWN = 2'd3
    } state_t;

    // Light patterns ordered {green, yellow, red}
    localparam logic [2:0] LIGHTS_GREEN  = 3'b100;
    localparam logic [2:0] LIGHTS_YELLOW = 3'b010;
    localparam logic [2:0] LIGHTS_RED    = 3'b001;

    localparam int SUSP_W  = 5;
    localparam int QUIET_W = 6;

    // LOCKDOWN shows the red light, same as RED
    function automatic logic [2:0] lights_of(input state_t s);
        case (s)
            GREEN:   return LIGHTS_GREEN;
            YELLOW:  return LIGHTS_YELLOW;
            default: return LIGHTS_RED;
        endcase
    endfunction

endpackage

// File: rtl/sec_cooldown_ctr.sv
// Consecutive-quiet-sample counter; done flags the sample that completes the cooldown run.
module sec_cooldown_ctr
    import threat_pkg::*;
#(
    parameter int COOLDOWN = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam logic [QUIET_W-1:0] CNT_LAST = QUIET_W'(COOLDOWN - 1);

    logic [QUIET_W-1:0] quiet_cnt_reg;

    // done is combinational so the de-escalation lands on the same edge as the sample
    assign done = inc && (quiet_cnt_reg == CNT_LAST);

    // Count quiet samples, restarting whenever the run is broken or the state moves
    always_ff @(posedge clock) begin
        if (reset) begin
            quiet_cnt_reg <= '0;
        end else if (clear) begin
            quiet_cnt_reg <= '0;
        end else if (inc && (quiet_cnt_reg != '1)) begin
            quiet_cnt_reg <= quiet_cnt_reg + QUIET_W'(1);
        end
    end

endmodule

// File: rtl/threat_light_gen.sv
// Threat-light generator: escalates GREEN/YELLOW/RED/LOCKDOWN from agent activity.
// Optional build macro DECEPTION_FILTER_EN: while deception=1, a1 is treated as 0.
module threat_light_gen
    import threat_pkg::*;
#(
    parameter int YELLOW_THRESH = 8,
    parameter int WINDOW        = 16,
    parameter int COOLDOWN      = 12,
    parameter int TIMER_W       = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               a1,
    input  logic               a2,
    input  logic               a3,
    input  logic               deception,
    output logic               green,
    output logic               yellow,
    output logic               red,
    output logic [1:0]         level,
    output logic [TIMER_W-1:0] timer
);

    localparam int WIN_W = 5;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [SUSP_W-1:0] SUSP_MAX = '1;

    state_t               state_reg, state_next;
    logic [2:0]           lights_reg;
    logic [TIMER_W-1:0]   timer_reg;
    logic [WIN_W-1:0]     win_cnt_reg;
    logic [SUSP_W-1:0]    susp_cnt_reg;

    logic a1_eff;
    logic quiet;
    logic thresh_hit;
    logic win_wrap;
    logic state_change;
    logic cool_done;

`ifdef DECEPTION_FILTER_EN
    assign a1_eff = a1 && !deception;
`else
    logic unused_deception;
    assign unused_deception = deception;
    assign a1_eff           = a1;
`endif

    assign win_wrap     = (win_cnt_reg == WIN_LAST);
    // Threshold includes this edge's own sample, even on the wrap edge
    assign thresh_hit   = a1_eff && ((int'(susp_cnt_reg) + 1) >= YELLOW_THRESH);
    assign state_change = (state_next != state_reg);

    // Quiet-sample classification and next state, priority a3 > a2 > threshold/cooldown
    always_comb begin
        quiet      = 1'b0;
        state_next = state_reg;
        case (state_reg)
            GREEN: begin
                if (a3)              state_next = LOCKDOWN;
                else if (a2)         state_next = RED;
                else if (thresh_hit) state_next = YELLOW;
            end
            YELLOW: begin
                quiet = !a1_eff;
                if (a3)             state_next = LOCKDOWN;
                else if (a2)        state_next = RED;
                else if (cool_done) state_next = GREEN;
            end
            RED: begin
                quiet = !a1_eff && !a2;
                if (a3)             state_next = LOCKDOWN;
                else if (cool_done) state_next = YELLOW;
            end
            default: begin
                state_next = LOCKDOWN;
            end
        endcase
    end

    sec_cooldown_ctr #(
        .COOLDOWN(COOLDOWN)
    ) u_cooldown (
        .clock(clock),
        .reset(reset),
        .clear(state_change || !quiet),
        .inc  (quiet),
        .done (cool_done)
    );

    // State and lights register together so they never disagree
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= GREEN;
            lights_reg <= LIGHTS_GREEN;
        end else begin
            state_reg  <= state_next;
            lights_reg <= lights_of(state_next);
        end
    end

    // Time-in-state counter, restarting at 1 on entry and saturating at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_reg <= TIMER_W'(1);
        end else if (state_change) begin
            timer_reg <= TIMER_W'(1);
        end else if (timer_reg != '1) begin
            timer_reg <= timer_reg + TIMER_W'(1);
        end
    end

    // Free-running suspicion window; a1 tally is dropped on the wrap edge
    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt_reg  <= '0;
            susp_cnt_reg <= '0;
        end else begin
            win_cnt_reg <= win_wrap ? '0 : win_cnt_reg + WIN_W'(1);
            if (win_wrap) begin
                susp_cnt_reg <= '0;
            end else if (a1_eff && (susp_cnt_reg != SUSP_MAX)) begin
                susp_cnt_reg <= susp_cnt_reg + SUSP_W'(1);
            end
        end
    end

    assign green  = lights_reg[2];
    assign yellow = lights_reg[1];
    assign red    = lights_reg[0];
    assign level  = state_reg;
    assign timer  = timer_reg;

endmodule

// File: tb/tb_threat_light_gen.sv
// Directed bench for threat_light_gen with an in-bench behavioural model checked every cycle.
module tb_threat_light_gen;

    localparam int THR  = 8;
    localparam int WIN  = 16;
    localparam int CD   = 12;
    localparam int TMAX = 63;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, deception = 1'b0;
    logic       green, yellow, red;
    logic [1:0] level;
    logic [5:0] timer;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: level code, time in level, position in window, a1 seen this window, quiet run
    int m_level = 0;
    int m_timer = 1;
    int m_pos   = 0;
    int m_hits  = 0;
    int m_quiet = 0;

    threat_light_gen #(
        .YELLOW_THRESH(THR),
        .WINDOW(WIN),
        .COOLDOWN(CD),
        .TIMER_W(6)
    ) dut (
        .clock(clock),
        .reset(reset),
        .a1(a1),
        .a2(a2),
        .a3(a3),
        .deception(deception),
        .green(green),
        .yellow(yellow),
        .red(red),
        .level(level),
        .timer(timer)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lights(input int lvl);
        if (lvl == 0) return 4;
        if (lvl == 1) return 2;
        return 1;
    endfunction

    // Apply the rules to the inputs about to be sampled
    task automatic model_edge();
        int  nxt;
        int  seen;
        bit  a1e;
        bit  q;
        if (reset) begin
            m_level = 0; m_timer = 1; m_pos = 0; m_hits = 0; m_quiet = 0;
            return;
        end
        a1e = a1;
`ifdef DECEPTION_FILTER_EN
        if (deception) a1e = 1'b0;
`endif
        seen = m_hits + (a1e ? 1 : 0);
        q    = (m_level == 1 && !a1e) || (m_level == 2 && !a1e && !a2);
        nxt  = m_level;
        if (m_level == 3 || a3)                          nxt = 3;
        else if (a2 && m_level < 2)                      nxt = 2;
        else if (m_level == 0 && a1e && seen >= THR)     nxt = 1;
        else if (q && (m_quiet + 1 == CD))               nxt = m_level - 1;
        m_quiet = (q && nxt == m_level) ? m_quiet + 1 : 0;
        m_timer = (nxt != m_level) ? 1 : ((m_timer < TMAX) ? m_timer + 1 : TMAX);
        m_level = nxt;
        m_hits  = (m_pos == WIN - 1) ? 0 : ((seen > 31) ? 31 : seen);
        m_pos   = (m_pos + 1) % WIN;
    endtask

    // One transaction: drive on the falling edge, let the rising edge sample it
    task automatic step(input logic r, input logic i1, input logic i2, input logic i3, input logic dec);
        @(negedge clock);
        reset = r; a1 = i1; a2 = i2; a3 = i3; deception = dec;
        model_edge();
        @(posedge clock);
        #2;
        $display("[TB] rst=%0d a1=%0d a2=%0d a3=%0d dec=%0d -> level=%0d gyr=%0d%0d%0d timer=%0d",
                 r, i1, i2, i3, dec, level, green, yellow, red, timer);
    endtask

    task automatic align();
        while (m_pos != 0) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every-cycle comparison against the model, just after each rising edge
    always @(posedge clock) begin
        #1;
        check("level", int'(level), m_level);
        check("lights", int'({green, yellow, red}), exp_lights(m_level));
        check("timer", int'(timer), m_timer);
    end

    initial begin
        // 1: reset then idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1 reset timer", int'(timer), 1);
        check("t1 reset green", int'(green), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1 timer 2", int'(timer), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1 timer 3", int'(timer), 3);
        check("t1 level", int'(level), 0);

        // 2: eight a1 samples -> YELLOW, twelve quiet -> GREEN
        align();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 6) check("t2 no yellow at 7th", int'(yellow), 0);
        end
        check("t2 yellow at 8th", int'(yellow), 1);
        check("t2 timer reset", int'(timer), 1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 10) check("t2 still yellow at 11th", int'(level), 1);
        end
        check("t2 green at 12th", int'(green), 1);
        check("t2 timer after cooldown", int'(timer), 1);

        // 3: 7 in one window, 1 in next -> stays GREEN
        align();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        align();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3 window split stays green", int'(level), 0);

        // 4: YELLOW, a1+a2 -> RED, cooldown twice
        align();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4 yellow", int'(level), 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4 red", int'(red), 1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4 red->yellow", int'(level), 1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4 yellow->green", int'(level), 0);

        // 5: RED then LOCKDOWN, random activity, then reset
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5 red", int'(level), 2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5 lockdown", int'(level), 3);
        check("t5 lockdown red", int'(red), 1);
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t5 still lockdown", int'(level), 3);
        check("t5 timer saturated", int'(timer), 63);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5 reset green", int'(green), 1);
        check("t5 reset level", int'(level), 0);

        // Reset mid-escalation clears the a1 tally
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst mid tally cleared", int'(level), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst mid 8th yellow", int'(level), 1);

        // Threshold and a2 on the same edge -> RED
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("simul thresh+a2 red", int'(level), 2);
        check("simul timer", int'(timer), 1);

        // 6: deception with a1
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifndef DECEPTION_FILTER_EN
            if (i == 7) check("t6 yellow at 8th", int'(level), 1);
`endif
        end
`ifdef DECEPTION_FILTER_EN
        check("t6 filtered stays green", int'(level), 0);
`else
        check("t6 unfiltered yellow", int'(level), 1);
`endif

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
